// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory stream reader.
//   - FSM state encoding
//   - configuration legality constants and check
//   - valid/ready handshake convention
package mem_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } stateE;

    localparam int MIN_MEM_LATENCY = 1;
    localparam int MAX_MEM_LATENCY = 4;
    // One slot for the word being written while another is being popped.
    localparam int BUF_HEADROOM    = 2;

    // Streams transfer when valid and ready are both at this level.
    localparam logic STREAM_ACTIVE = 1'b1;

    function automatic bit cfgLegal(input int bufDepth, input int memLatency);
        return (memLatency >= MIN_MEM_LATENCY) && (memLatency <= MAX_MEM_LATENCY) &&
               (bufDepth >= memLatency + BUF_HEADROOM) &&
               ((bufDepth & (bufDepth - 1)) == 0);
    endfunction

    function automatic logic fire(input logic valid, input logic ready);
        return (valid == STREAM_ACTIVE) && (ready == STREAM_ACTIVE);
    endfunction

endpackage

// File: rtl/mem_stream_reader_buf.sv
// Circular return buffer for mem_stream_reader.
//   clkIn/rstIn : clock, synchronous active-low reset
//   push/pushData : write one entry at the tail
//   pop          : drop the head entry
//   headData     : entry at the head (valid when !empty)
//   empty        : no entries held
// Overflow is prevented upstream by the credit counter, so there is no full flag.
module stream_reader_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the indices match.
    logic [AW:0]      wrPtr, rdPtr;

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wrPtr[AW-1:0]] <= pushData;
                wrPtr <= wrPtr + (AW+1)'(1);
            end
            if (pop) rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    assign empty    = (wrPtr == rdPtr);
    assign headData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/mem_stream_reader.sv
// DMA-style reader: takes {address, length} commands, issues reads to a
// fixed-latency synchronous RAM and pushes returned words, in order, onto a
// valid/ready stream. A credit counter (reads in flight + words buffered)
// caps outstanding reads at BUF_DEPTH so nothing is dropped under back-pressure.
// Ports:
//   clkIn, rstIn (sync, active-low)
//   cmdAddrIn/cmdLenIn/cmdValidIn/cmdReadyOut : command
//   memAddrOut/memRdEnOut/memDataIn           : RAM read port
//   wrDataOut/wrValidOut/wrReadyIn            : output stream
//   busyOut, doneOut                          : status
// Optional: define MEM_STREAM_READER_LAST_EN to add wrLastOut, high with the
// final word of each command.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH   = 16,
    parameter int MEM_LATENCY = 1,
    parameter int BUF_DEPTH   = 4
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic [ADDR_WIDTH-1:0] cmdAddrIn,
    input  logic [LEN_WIDTH-1:0]  cmdLenIn,
    input  logic                  cmdValidIn,
    output logic                  cmdReadyOut,
    output logic [ADDR_WIDTH-1:0] memAddrOut,
    output logic                  memRdEnOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    output logic [DATA_WIDTH-1:0] wrDataOut,
    output logic                  wrValidOut,
    input  logic                  wrReadyIn,
    output logic                  busyOut,
`ifdef MEM_STREAM_READER_LAST_EN
    output logic                  wrLastOut,
`endif
    output logic                  doneOut
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
`ifdef MEM_STREAM_READER_LAST_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif

    generate
        if (!cfgLegal(BUF_DEPTH, MEM_LATENCY)) begin : gBadCfg
            $error("mem_stream_reader: illegal BUF_DEPTH/MEM_LATENCY");
        end
    endgenerate

    stateE                 state, stateNext;
    logic [ADDR_WIDTH-1:0] addrR;
    logic [LEN_WIDTH-1:0]  remR;
    logic [CW-1:0]         creditR;
    logic [MEM_LATENCY:1]  vldPipe;
    logic                  upR;        // first edge out of reset has passed
    logic                  doneZeroR;  // zero-length command completion
    logic                  cmdFire, issue, pop, bufEmpty;
    logic [EW-1:0]         pushData, headData;

    assign cmdFire = fire(cmdValidIn, cmdReadyOut);
    assign issue   = memRdEnOut;
    assign pop     = fire(wrValidOut, wrReadyIn);

    always_ff @(posedge clkIn) begin
        if (!rstIn) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        memRdEnOut = 1'b0;
        doneOut    = doneZeroR;
        case (state)
            IDLE: if (cmdFire && cmdLenIn != '0) stateNext = ISSUE;
            ISSUE: begin
                memRdEnOut = (remR != '0) && (creditR < CW'(BUF_DEPTH));
                if (memRdEnOut && remR == LEN_WIDTH'(1)) stateNext = DRAIN;
            end
            DRAIN: if (creditR == '0) begin
                doneOut   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            addrR     <= '0;
            remR      <= '0;
            creditR   <= '0;
            vldPipe   <= '0;
            upR       <= 1'b0;
            doneZeroR <= 1'b0;
        end else begin
            upR       <= 1'b1;
            doneZeroR <= cmdFire && (cmdLenIn == '0);
            if (cmdFire) begin
                addrR <= cmdAddrIn;
                remR  <= cmdLenIn;
            end else if (issue) begin
                addrR <= addrR + ADDR_WIDTH'(1);
                remR  <= remR - LEN_WIDTH'(1);
            end
            if (issue && !pop)      creditR <= creditR + CW'(1);
            else if (!issue && pop) creditR <= creditR - CW'(1);
            // vldPipe[MEM_LATENCY] lines up with memDataIn for each read.
            vldPipe[1] <= issue;
            for (int i = 2; i <= MEM_LATENCY; i++) vldPipe[i] <= vldPipe[i-1];
        end
    end

`ifdef MEM_STREAM_READER_LAST_EN
    logic [MEM_LATENCY:1] lastPipe;
    always_ff @(posedge clkIn) begin
        if (!rstIn) lastPipe <= '0;
        else begin
            lastPipe[1] <= issue && (remR == LEN_WIDTH'(1));
            for (int i = 2; i <= MEM_LATENCY; i++) lastPipe[i] <= lastPipe[i-1];
        end
    end
    assign pushData  = {lastPipe[MEM_LATENCY], memDataIn};
    assign wrLastOut = wrValidOut & headData[DATA_WIDTH];
`else
    assign pushData  = memDataIn;
`endif

    stream_reader_buf #(.DEPTH(BUF_DEPTH), .WIDTH(EW)) retBuf (
        .clkIn    (clkIn),
        .rstIn    (rstIn),
        .push     (vldPipe[MEM_LATENCY]),
        .pushData (pushData),
        .pop      (pop),
        .headData (headData),
        .empty    (bufEmpty)
    );

    assign wrDataOut   = headData[DATA_WIDTH-1:0];
    assign wrValidOut  = !bufEmpty;
    assign memAddrOut  = addrR;
    assign cmdReadyOut = upR && (state == IDLE);
    assign busyOut     = (state != IDLE);

endmodule

// File: tb/tb_mem_stream_reader.sv
// Drives two readers in lockstep: A (latency 1, depth 4) and B (latency 3,
// depth 8). A scoreboard built from the command stream (expected addresses,
// words and last flags) checks every RAM read and every stream transfer.
module tb_mem_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, cmdValid, wrReady;
    logic [15:0] cmdAddr, cmdLen;
    logic [1:0]  cmdReady, memRdEn, wrValid, busy, done;
    logic [1:0][15:0] memAddr;
    logic [1:0][31:0] wrData;
    logic [31:0] memDataA, memDataB;
    logic [31:0] pipeB [3];
`ifdef MEM_STREAM_READER_LAST_EN
    logic [1:0]  wrLast;
    bit          lastQ [2][$];
`endif

    int nVec = 0, nErr = 0;

    logic [31:0] expQ [2][$];
    logic [15:0] adrQ [2][$];
    int          iss [2], pops [2], doneCnt [2];
    bit          stall [2];
    logic [31:0] stallData [2];

    mem_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16),
                        .MEM_LATENCY(1), .BUF_DEPTH(4)) dutA (
        .clkIn(clk), .rstIn(rstN), .cmdAddrIn(cmdAddr), .cmdLenIn(cmdLen),
        .cmdValidIn(cmdValid), .cmdReadyOut(cmdReady[0]), .memAddrOut(memAddr[0]),
        .memRdEnOut(memRdEn[0]), .memDataIn(memDataA), .wrDataOut(wrData[0]),
        .wrValidOut(wrValid[0]), .wrReadyIn(wrReady), .busyOut(busy[0]),
`ifdef MEM_STREAM_READER_LAST_EN
        .wrLastOut(wrLast[0]),
`endif
        .doneOut(done[0]));

    mem_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16),
                        .MEM_LATENCY(3), .BUF_DEPTH(8)) dutB (
        .clkIn(clk), .rstIn(rstN), .cmdAddrIn(cmdAddr), .cmdLenIn(cmdLen),
        .cmdValidIn(cmdValid), .cmdReadyOut(cmdReady[1]), .memAddrOut(memAddr[1]),
        .memRdEnOut(memRdEn[1]), .memDataIn(memDataB), .wrDataOut(wrData[1]),
        .wrValidOut(wrValid[1]), .wrReadyIn(wrReady), .busyOut(busy[1]),
`ifdef MEM_STREAM_READER_LAST_EN
        .wrLastOut(wrLast[1]),
`endif
        .doneOut(done[1]));

    function automatic logic [31:0] memWord(input logic [15:0] a);
        return 32'h1000 + 32'(a);
    endfunction

    // RAM models: data appears MEM_LATENCY cycles after the read strobe;
    // garbage otherwise so unrequested words are never accidentally right.
    always @(posedge clk)
        memDataA <= memRdEn[0] ? memWord(memAddr[0]) : 32'($urandom());
    always @(posedge clk) begin
        pipeB[0] <= memRdEn[1] ? memWord(memAddr[1]) : 32'($urandom());
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign memDataB = pipeB[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic readyAt(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return (n % 4 == 0) || (n % 4 == 3);   // 1,0,0,1 ...
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rstN) begin
                    expQ[d].delete(); adrQ[d].delete();
                    iss[d] = 0; pops[d] = 0; stall[d] = 0; doneCnt[d] = 0;
`ifdef MEM_STREAM_READER_LAST_EN
                    lastQ[d].delete();
`endif
                end else begin
                    if (iss[d] - pops[d] >= ((d == 0) ? 4 : 8))
                        chk($sformatf("rdEnAtFullCredit%0d", d), 64'(memRdEn[d]), 0);
                    if (memRdEn[d]) begin
                        if (adrQ[d].size() == 0) chk($sformatf("spuriousRdEn%0d", d), 64'(memRdEn[d]), 0);
                        else chk($sformatf("memAddr%0d", d), 64'(memAddr[d]), 64'(adrQ[d].pop_front()));
                        iss[d]++;
                    end
                    if (stall[d]) begin
                        chk($sformatf("holdValid%0d", d), 64'(wrValid[d]), 1);
                        chk($sformatf("holdData%0d", d), 64'(wrData[d]), 64'(stallData[d]));
                    end
                    if (wrValid[d] && wrReady) begin
                        if (expQ[d].size() == 0) chk($sformatf("spuriousValid%0d", d), 64'(wrValid[d]), 0);
                        else begin
                            chk($sformatf("wrData%0d", d), 64'(wrData[d]), 64'(expQ[d].pop_front()));
`ifdef MEM_STREAM_READER_LAST_EN
                            chk($sformatf("wrLast%0d", d), 64'(wrLast[d]), 64'(lastQ[d].pop_front()));
`endif
                        end
                        pops[d]++;
                    end
                    stall[d]     = wrValid[d] && !wrReady;
                    stallData[d] = wrData[d];
                    if (done[d]) doneCnt[d]++;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        int          mode;
        int          firstA, firstB;   // sample index of first valid, -1 = never
        int          doneA, doneB;     // sample index of done, -1 = not checked
    } vec_t;

    task automatic waitReady();
        int n = 0;
        while (!(cmdReady[0] && cmdReady[1]) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("cmdReadyBeforeCmdA", 64'(cmdReady[0]), 1);
        chk("cmdReadyBeforeCmdB", 64'(cmdReady[1]), 1);
    endtask

    task automatic sendCmd(input logic [15:0] a, input logic [15:0] l);
        cmdAddr = a; cmdLen = l; cmdValid = 1'b1;
        @(posedge clk); #1;
        cmdValid = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(l); i++) begin
                expQ[d].push_back(memWord(a + 16'(i)));
                adrQ[d].push_back(a + 16'(i));
`ifdef MEM_STREAM_READER_LAST_EN
                lastQ[d].push_back(i == int'(l) - 1);
`endif
            end
    endtask

    // Sample n is taken 1 time unit after the n-th edge following the
    // handshake edge (n = 0 is right after the handshake).
    task automatic runCmd(input vec_t v);
        int firstV [2], doneN [2], expF [2], expD [2];
        expF = '{v.firstA, v.firstB};
        expD = '{v.doneA, v.doneB};
        firstV = '{-1, -1};
        doneN  = '{-1, -1};
        waitReady();
        doneCnt[0] = 0; doneCnt[1] = 0;
        wrReady = readyAt(v.mode, 0);
        sendCmd(v.addr, v.len);
        for (int n = 0; n <= 1000; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (n == 0) chk($sformatf("cmdReadyAfterHs%0d", d), 64'(cmdReady[d]), 64'(v.len == 0));
                if (wrValid[d] && firstV[d] < 0) firstV[d] = n;
                if (done[d] && doneN[d] < 0) doneN[d] = n;
                if (doneN[d] >= 0 && n == doneN[d] + 1) begin
                    chk($sformatf("busyAfterDone%0d", d), 64'(busy[d]), 0);
                    chk($sformatf("cmdReadyAfterDone%0d", d), 64'(cmdReady[d]), 1);
                end
            end
            if (doneN[0] >= 0 && doneN[1] >= 0 && n >= doneN[0] + 3 && n >= doneN[1] + 3) break;
            wrReady = readyAt(v.mode, n + 1);
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("firstValid%0d", d), 64'(firstV[d]), 64'(expF[d]));
            if (expD[d] >= 0) chk($sformatf("doneLatency%0d", d), 64'(doneN[d]), 64'(expD[d]));
            else              chk($sformatf("doneSeen%0d", d), 64'(doneN[d] >= 0), 1);
            chk($sformatf("donePulses%0d", d), 64'(doneCnt[d]), 1);
            chk($sformatf("wordsLeft%0d", d), 64'(expQ[d].size()), 0);
        end
        wrReady = 1'b1;
    endtask

    task automatic chkAllZero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s cmdReady%0d", tag, d), 64'(cmdReady[d]), 0);
            chk($sformatf("%s busy%0d", tag, d), 64'(busy[d]), 0);
            chk($sformatf("%s done%0d", tag, d), 64'(done[d]), 0);
            chk($sformatf("%s memRdEn%0d", tag, d), 64'(memRdEn[d]), 0);
            chk($sformatf("%s wrValid%0d", tag, d), 64'(wrValid[d]), 0);
            chk($sformatf("%s memAddr%0d", tag, d), 64'(memAddr[d]), 0);
            chk($sformatf("%s wrData%0d", tag, d), 64'(wrData[d]), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        vec_t rv;
        // First valid after L+1 edges (consumed at edge L+2); with ready held
        // high the last word pops len-1 edges later and done follows.
        tbl[0] = '{16'h0008, 16'd5,  0,  2,  4,  7,  9};  // basic
        tbl[1] = '{16'h0020, 16'd16, 1,  2,  4, -1, -1};  // back-pressure 1001
        tbl[2] = '{16'h0040, 16'd0,  0, -1, -1,  0,  0};  // zero length
        tbl[3] = '{16'hFFFE, 16'd4,  0,  2,  4,  6,  8};  // address wrap
        tbl[4] = '{16'h0100, 16'd1,  0,  2,  4,  3,  5};  // single word
        tbl[5] = '{16'h0200, 16'd20, 0,  2,  4, 22, 24};  // long, full rate

        rstN = 1'b0; cmdValid = 1'b0; cmdAddr = '0; cmdLen = '0; wrReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 chkAllZero("reset");
        rstN = 1'b1;
        @(posedge clk); #1;
        chk("cmdReadyAfterResetA", 64'(cmdReady[0]), 1);
        chk("cmdReadyAfterResetB", 64'(cmdReady[1]), 1);

        for (int i = 0; i < 6; i++) runCmd(tbl[i]);

        // Reset mid-transfer: abandon after three issues.
        waitReady();
        wrReady = 1'b1;
        sendCmd(16'h0300, 16'd10);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b0;
        @(posedge clk); #1;
        chkAllZero("midReset");
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        chk("cmdReadyAfterReleaseA", 64'(cmdReady[0]), 1);
        chk("cmdReadyAfterReleaseB", 64'(cmdReady[1]), 1);
        repeat (12) @(posedge clk);
        #1;
        chk("noDoneAfterResetA", 64'(doneCnt[0]), 0);
        chk("noDoneAfterResetB", 64'(doneCnt[1]), 0);
        rv = '{16'h0400, 16'd2, 0, 2, 4, 4, 6};
        runCmd(rv);

        // Random commands with random back-pressure.
        for (int k = 0; k < 10; k++) begin
            rv = '{16'($urandom()), 16'($urandom_range(1, 24)), 2, 2, 4, -1, -1};
            runCmd(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
